// File: rtl/seq_word_adder.sv
// Multi-cycle word adder: walks the operands two bits per cycle through a 2-bit
// ripple slice, LSB pair first, under a start/busy/done handshake.
module seq_word_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int N  = WIDTH / 2;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cMid_q, cMid_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic s0, c1, s1, co;
  logic lastPair;
  logic [WIDTH-1:0] accShifted;

  // The 2-bit slice, identical to the downstream adder core.
  always_comb begin
    s0 = opA_q[0] ^ opB_q[0] ^ carry_q;
    c1 = (opA_q[0] & opB_q[0]) | (opA_q[0] & carry_q) | (opB_q[0] & carry_q);
    s1 = opA_q[1] ^ opB_q[1] ^ c1;
    co = (opA_q[1] & opB_q[1]) | (opA_q[1] & c1) | (opB_q[1] & c1);
  end

  assign lastPair   = (cnt_q == CW'(N - 1));
  // New result pair enters from the top so the LSB pair ends up at bit 0.
  assign accShifted = (WIDTH'({s1, s0}) << (WIDTH - 2)) | (acc_q >> 2);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (lastPair) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == RUN);
    done_o = (state_q == DONE);
  end

  always_comb begin
    opA_d   = opA_q;
    opB_d   = opB_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cMid_d  = cMid_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          opA_d   = a_i;
          opB_d   = b_i;
          carry_d = cin_i;
          cnt_d   = '0;
        end
      end
      RUN: begin
        acc_d   = accShifted;
        carry_d = co;
        cMid_d  = c1;
        opA_d   = opA_q >> 2;
        opB_d   = opB_q >> 2;
        cnt_d   = cnt_q + CW'(1);
        if (lastPair) begin
          sum_d  = accShifted;
          cout_d = co;
          ovf_d  = c1 ^ co;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      opA_q   <= '0;
      opB_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cMid_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cMid_q  <= cMid_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // cMid_q is the pair-MSB carry kept for observation; overflow uses it live as c1.
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_seq_word_adder.sv
// Bench for seq_word_adder: directed table, handshake corner cases, and a random
// regression on WIDTH 2, 8 and 16 against plain-arithmetic addition.
module tb_seq_word_adder;

  logic clk;
  logic rst;
  int compared;
  int mismatched;

  int widths[3] = '{2, 8, 16};

  logic [15:0] aV[3];
  logic [15:0] bV[3];
  logic        cinV[3];
  logic        startV[3];

  logic        busyV[3];
  logic        doneV[3];
  logic        coutV[3];
  logic        ovfV[3];
  logic [15:0] sumV[3];

  logic [1:0]  sum2;
  logic [7:0]  sum8;
  logic [15:0] sum16;

  logic [15:0] lastExpSum;
  logic        lastExpCout;
  logic        lastExpOvf;

  seq_word_adder #(.WIDTH(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(startV[0]),
    .a_i(aV[0][1:0]), .b_i(bV[0][1:0]), .cin_i(cinV[0]),
    .busy_o(busyV[0]), .done_o(doneV[0]), .sum_o(sum2),
    .cout_o(coutV[0]), .ovf_o(ovfV[0])
  );

  seq_word_adder #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(startV[1]),
    .a_i(aV[1][7:0]), .b_i(bV[1][7:0]), .cin_i(cinV[1]),
    .busy_o(busyV[1]), .done_o(doneV[1]), .sum_o(sum8),
    .cout_o(coutV[1]), .ovf_o(ovfV[1])
  );

  seq_word_adder #(.WIDTH(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .start_i(startV[2]),
    .a_i(aV[2]), .b_i(bV[2]), .cin_i(cinV[2]),
    .busy_o(busyV[2]), .done_o(doneV[2]), .sum_o(sum16),
    .cout_o(coutV[2]), .ovf_o(ovfV[2])
  );

  assign sumV[0] = {14'b0, sum2};
  assign sumV[1] = {8'b0, sum8};
  assign sumV[2] = sum16;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] expSum;
    logic       expCout;
    logic       expOvf;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: widen, add, split into carry/sum; overflow from operand/result signs.
  task automatic modelAdd(input int w, input logic [15:0] a, input logic [15:0] b, input logic cin,
                          output logic [15:0] s, output logic c, output logic v);
    logic [16:0] full;
    logic [16:0] mask;
    mask = (17'd1 << w) - 17'd1;
    full = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {16'd0, cin};
    s = 16'(full & mask);
    c = full[w];
    v = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
  endtask

  // Runs one operation from IDLE and returns to IDLE one cycle after Done.
  task automatic applyStimulus(input int idx, input logic [15:0] a, input logic [15:0] b,
                               input logic cin, output logic [15:0] s, output logic c,
                               output logic v, output int lat, output int busyCnt,
                               output logic heldOk);
    int n;
    n = widths[idx] / 2;
    aV[idx] = a;
    bV[idx] = b;
    cinV[idx] = cin;
    startV[idx] = 1'b1;
    @(posedge clk); #1;
    startV[idx] = 1'b0;
    aV[idx] = 16'($urandom);
    bV[idx] = 16'($urandom);
    cinV[idx] = 1'($urandom);
    lat = 0;
    busyCnt = 0;
    heldOk = 1'b1;
    while (!doneV[idx] && lat < n + 3) begin
      if (busyV[idx]) busyCnt++;
      if (sumV[idx] !== lastExpSum || coutV[idx] !== lastExpCout || ovfV[idx] !== lastExpOvf)
        heldOk = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    s = sumV[idx];
    c = coutV[idx];
    v = ovfV[idx];
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    lastExpSum = '0;
    lastExpCout = 1'b0;
    lastExpOvf = 1'b0;
  endtask

  initial begin
    logic [15:0] s;
    logic        c;
    logic        v;
    logic [15:0] es;
    logic        ec;
    logic        ev;
    int lat;
    int busyCnt;
    logic heldOk;
    int n;
    int nextFree;
    int doneDue;
    int doneCnt;
    logic [15:0] pendSum;
    logic        pendCout;
    logic        pendOvf;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;

    compared = 0;
    mismatched = 0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      aV[i] = 16'hA5A5;
      bV[i] = 16'h5A5A;
      cinV[i] = 1'b1;
      startV[i] = 1'b0;
    end

    vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    doReset();

    checkOutput("reset busy", 32'(busyV[1]), 32'd0);
    checkOutput("reset done", 32'(doneV[1]), 32'd0);
    checkOutput("reset sum", 32'(sumV[1]), 32'd0);
    checkOutput("reset cout", 32'(coutV[1]), 32'd0);
    checkOutput("reset ovf", 32'(ovfV[1]), 32'd0);

    // Directed table on the 8-bit instance, including Done latency and Busy length.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1, {8'h00, vecs[i].a}, {8'h00, vecs[i].b}, vecs[i].cin,
                    s, c, v, lat, busyCnt, heldOk);
      checkOutput($sformatf("vec%0d sum", i), 32'(s), 32'(vecs[i].expSum));
      checkOutput($sformatf("vec%0d cout", i), 32'(c), 32'(vecs[i].expCout));
      checkOutput($sformatf("vec%0d ovf", i), 32'(v), 32'(vecs[i].expOvf));
      checkOutput($sformatf("vec%0d done latency", i), 32'(lat), 32'd4);
      checkOutput($sformatf("vec%0d busy cycles", i), 32'(busyCnt), 32'd4);
      checkOutput($sformatf("vec%0d outputs held in run", i), 32'(heldOk), 32'd1);
      lastExpSum = {8'h00, vecs[i].expSum};
      lastExpCout = vecs[i].expCout;
      lastExpOvf = vecs[i].expOvf;
    end

    // Start held high, operands changing every cycle: an op is accepted every N+2 edges.
    n = 4;
    nextFree = 0;
    doneDue = -1;
    doneCnt = 0;
    pendSum = '0;
    pendCout = 1'b0;
    pendOvf = 1'b0;
    startV[1] = 1'b1;
    for (int cyc = 0; cyc < 36; cyc++) begin
      ra = 16'($urandom_range(0, 255));
      rb = 16'($urandom_range(0, 255));
      rc = 1'($urandom);
      aV[1] = ra;
      bV[1] = rb;
      cinV[1] = rc;
      if (cyc >= nextFree) begin
        modelAdd(8, ra, rb, rc, pendSum, pendCout, pendOvf);
        doneDue = cyc + n;
        nextFree = cyc + n + 2;
      end
      @(posedge clk); #1;
      checkOutput($sformatf("stream done @%0d", cyc), 32'(doneV[1]), 32'(cyc == doneDue));
      if (cyc == doneDue) begin
        doneCnt++;
        lastExpSum = pendSum;
        lastExpCout = pendCout;
        lastExpOvf = pendOvf;
      end
      checkOutput($sformatf("stream sum @%0d", cyc), 32'(sumV[1]), 32'(lastExpSum));
      checkOutput($sformatf("stream cout/ovf @%0d", cyc), {30'd0, coutV[1], ovfV[1]},
                  {30'd0, lastExpCout, lastExpOvf});
    end
    startV[1] = 1'b0;
    checkOutput("stream done count", 32'(doneCnt), 32'd6);
    repeat (6) @(posedge clk);
    #1;

    // Reset during the second RUN cycle aborts the op with no Done.
    aV[1] = 16'h0012;
    bV[1] = 16'h0034;
    cinV[1] = 1'b1;
    startV[1] = 1'b1;
    @(posedge clk); #1;
    startV[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort busy", 32'(busyV[1]), 32'd0);
    checkOutput("abort done", 32'(doneV[1]), 32'd0);
    checkOutput("abort sum", 32'(sumV[1]), 32'd0);
    lastExpSum = '0;
    lastExpCout = 1'b0;
    lastExpOvf = 1'b0;
    doneCnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (doneV[1]) doneCnt++;
    end
    checkOutput("abort no done", 32'(doneCnt), 32'd0);
    applyStimulus(1, 16'h0012, 16'h0034, 1'b1, s, c, v, lat, busyCnt, heldOk);
    checkOutput("post-abort sum", 32'(s), 32'h47);
    checkOutput("post-abort latency", 32'(lat), 32'd4);
    lastExpSum = 16'h0047;

    // Start coinciding with reset in IDLE is dropped.
    rst = 1'b1;
    startV[1] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    startV[1] = 1'b0;
    checkOutput("rst+start busy", 32'(busyV[1]), 32'd0);
    @(posedge clk); #1;
    checkOutput("rst+start busy later", 32'(busyV[1]), 32'd0);
    lastExpSum = '0;
    lastExpCout = 1'b0;
    lastExpOvf = 1'b0;

    // Random regression per width against plain addition.
    for (int idx = 0; idx < 3; idx++) begin
      lastExpSum = '0;
      lastExpCout = 1'b0;
      lastExpOvf = 1'b0;
      for (int k = 0; k < 1000; k++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        rc = 1'($urandom);
        if (widths[idx] < 16) begin
          ra = ra & 16'((1 << widths[idx]) - 1);
          rb = rb & 16'((1 << widths[idx]) - 1);
        end
        applyStimulus(idx, ra, rb, rc, s, c, v, lat, busyCnt, heldOk);
        modelAdd(widths[idx], ra, rb, rc, es, ec, ev);
        checkOutput($sformatf("w%0d op%0d result", widths[idx], k), {15'd0, c, v, s},
                    {15'd0, ec, ev, es});
        checkOutput($sformatf("w%0d op%0d latency", widths[idx], k), 32'(lat),
                    32'(widths[idx] / 2));
        lastExpSum = es;
        lastExpCout = ec;
        lastExpOvf = ev;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
